// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: imm_src codes, FSM state
// encoding, rotation count and the even-rotate helper used by the search.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        IMM_DP  = 2'b00,
        IMM_MEM = 2'b01,
        IMM_BR  = 2'b10,
        IMM_RSV = 2'b11
    } imm_src_t;

    typedef logic [1:0] imm_enc_state_t;

    localparam imm_enc_state_t ST_IDLE       = 2'd0;
    localparam imm_enc_state_t ST_SEARCH     = 2'd1;
    localparam imm_enc_state_t ST_ALT_SEARCH = 2'd2;
    localparam imm_enc_state_t ST_DONE       = 2'd3;

    localparam int NUM_ROTS = 16;

    // Rotate left by 2*r; the r=0 case relies on a 32-bit shift yielding zero.
    function automatic logic [31:0] rotl2(input logic [31:0] v, input logic [3:0] r);
        logic [5:0] sh;
        sh = {1'b0, r, 1'b0};
        return (v << sh) | (v >> (6'd32 - sh));
    endfunction

endpackage

// File: rtl/imm_encoder_rot_check.sv
// Combinational check of one rotation candidate: does rotl(value, 2*rot)
// fit in eight bits, and if so what is the resulting imm8.
module imm_rot_check
    import imm_encoder_pkg::*;
(
    input  logic [31:0] value,
    input  logic [3:0]  rot,
    output logic        match,
    output logic [7:0]  imm8
);

    logic [31:0] rotated;

    assign rotated = rotl2(value, rot);
    assign match   = (rotated[31:8] == 24'd0);
    assign imm8    = rotated[7:0];

endmodule

// File: rtl/imm_encoder.sv
// Iterative immediate encoder: turns a 32-bit constant into the 24-bit
// instr_imm field for the selected imm_src. Optional MVN retry: IMM_ENCODER_ALT_EN.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int ROTS_PER_CYCLE = 1   // 1, 2, 4, 8 or 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    input  logic [1:0]  imm_src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] instr_imm,
    output logic        err,
    output logic        alt
);

    imm_enc_state_t state_reg, state_next;
    logic [3:0]     rot_reg, rot_next;
    logic [31:0]    value_reg, value_next;
    logic [23:0]    instr_imm_reg, instr_imm_next;
    logic           err_reg, err_next;
`ifdef IMM_ENCODER_ALT_EN
    logic           alt_reg, alt_next;
`endif

    imm_src_t    src;
    logic [31:0] search_value;
    logic [4:0]  rot_sum;
    logic        rot_wrap;
    logic        mem_legal;
    logic        br_legal;

    assign src       = imm_src_t'(imm_src);
    assign rot_sum   = {1'b0, rot_reg} + 5'(ROTS_PER_CYCLE);
    assign rot_wrap  = rot_sum[4];
    assign mem_legal = (value[31:12] == 20'd0);
    assign br_legal  = (value[1:0] == 2'b00) && (value[31:25] == {7{value[25]}});

`ifdef IMM_ENCODER_ALT_EN
    assign search_value = (state_reg == ST_ALT_SEARCH) ? ~value_reg : value_reg;
`else
    assign search_value = value_reg;
`endif

    // One checker per candidate handled in a cycle.
    logic [ROTS_PER_CYCLE-1:0] cand_match;
    logic [3:0]                cand_rot  [ROTS_PER_CYCLE];
    logic [7:0]                cand_imm8 [ROTS_PER_CYCLE];

    generate
        for (genvar gi = 0; gi < ROTS_PER_CYCLE; gi++) begin : g_cand
            localparam logic [3:0] OFFSET = 4'(gi);
            assign cand_rot[gi] = rot_reg + OFFSET;
            imm_rot_check u_check (
                .value (search_value),
                .rot   (cand_rot[gi]),
                .match (cand_match[gi]),
                .imm8  (cand_imm8[gi])
            );
        end
    endgenerate

    // Walk from the top down so the lowest matching rotation is kept.
    logic       hit;
    logic [3:0] hit_rot;
    logic [7:0] hit_imm8;

    always_comb begin
        hit      = 1'b0;
        hit_rot  = 4'd0;
        hit_imm8 = 8'd0;
        for (int i = ROTS_PER_CYCLE - 1; i >= 0; i--) begin
            if (cand_match[i]) begin
                hit      = 1'b1;
                hit_rot  = cand_rot[i];
                hit_imm8 = cand_imm8[i];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        rot_next       = rot_reg;
        value_next     = value_reg;
        instr_imm_next = instr_imm_reg;
        err_next       = err_reg;
`ifdef IMM_ENCODER_ALT_EN
        alt_next       = alt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    value_next = value;
                    rot_next   = 4'd0;
                    case (src)
                        IMM_DP: begin
                            state_next = ST_SEARCH;
                        end
                        IMM_MEM: begin
                            state_next     = ST_DONE;
                            instr_imm_next = mem_legal ? {12'd0, value[11:0]} : 24'd0;
                            err_next       = !mem_legal;
                        end
                        IMM_BR: begin
                            state_next     = ST_DONE;
                            instr_imm_next = br_legal ? value[25:2] : 24'd0;
                            err_next       = !br_legal;
                        end
                        default: begin
                            state_next     = ST_DONE;
                            instr_imm_next = 24'd0;
                            err_next       = 1'b1;
                        end
                    endcase
                end
            end
            ST_SEARCH, ST_ALT_SEARCH: begin
                if (hit) begin
                    state_next     = ST_DONE;
                    instr_imm_next = {12'd0, hit_rot, hit_imm8};
                    err_next       = 1'b0;
`ifdef IMM_ENCODER_ALT_EN
                    alt_next       = (state_reg == ST_ALT_SEARCH);
`endif
                end else if (rot_wrap) begin
                    rot_next = 4'd0;
`ifdef IMM_ENCODER_ALT_EN
                    if (state_reg == ST_SEARCH) begin
                        state_next = ST_ALT_SEARCH;
                    end else begin
                        state_next     = ST_DONE;
                        instr_imm_next = 24'd0;
                        err_next       = 1'b1;
                        alt_next       = 1'b0;
                    end
`else
                    state_next     = ST_DONE;
                    instr_imm_next = 24'd0;
                    err_next       = 1'b1;
`endif
                end else begin
                    rot_next = rot_sum[3:0];
                end
            end
            default: begin
                if (out_ready) begin
                    state_next     = ST_IDLE;
                    instr_imm_next = 24'd0;
                    err_next       = 1'b0;
`ifdef IMM_ENCODER_ALT_EN
                    alt_next       = 1'b0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rot_reg       <= 4'd0;
            value_reg     <= 32'd0;
            instr_imm_reg <= 24'd0;
            err_reg       <= 1'b0;
`ifdef IMM_ENCODER_ALT_EN
            alt_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            rot_reg       <= rot_next;
            value_reg     <= value_next;
            instr_imm_reg <= instr_imm_next;
            err_reg       <= err_next;
`ifdef IMM_ENCODER_ALT_EN
            alt_reg       <= alt_next;
`endif
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign instr_imm = instr_imm_reg;
    assign err       = err_reg;
`ifdef IMM_ENCODER_ALT_EN
    assign alt       = alt_reg;
`else
    assign alt       = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: vector table plus reset-mid-search and
// backpressure sequences.
module tb_imm_encoder;

    localparam int RPC = 1;
`ifdef IMM_ENCODER_ALT_EN
    localparam bit ALT_ON = 1'b1;
`else
    localparam bit ALT_ON = 1'b0;
`endif
    localparam int FULL_FAIL = 16 / RPC;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic [1:0]  imm_src;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] instr_imm;
    logic        err;
    logic        alt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_encoder #(.ROTS_PER_CYCLE(RPC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .imm_src   (imm_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_imm (instr_imm),
        .err       (err),
        .alt       (alt)
    );

    typedef struct {
        logic [1:0]  src;
        logic [31:0] val;
        logic [23:0] exp_imm;
        logic        exp_err;
        logic        exp_alt;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];
    int   num_vecs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int dp_lat(input int r);
        return r / RPC + 1;
    endfunction

    // Issues one request; returns cycles from acceptance edge to out_valid.
    task automatic issue(input logic [1:0] src, input logic [31:0] v, output int lat);
        check("in_ready_before_req", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        imm_src  = src;
        value    = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic add_vec(input logic [1:0] s, input logic [31:0] v, input logic [23:0] i,
                           input logic e, input logic a, input int l);
        vecs[num_vecs] = '{src: s, val: v, exp_imm: i, exp_err: e, exp_alt: a, exp_lat: l};
        num_vecs++;
    endtask

    initial begin
        int lat;
        bit stayed_low;

        reset = 1'b1; in_valid = 1'b0; value = '0; imm_src = '0; out_ready = 1'b0;
        num_vecs = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_instr_imm", {8'd0, instr_imm},  32'd0);
        check("reset_err",       {31'd0, err},       32'd0);
        check("reset_alt",       {31'd0, alt},       32'd0);
        reset = 1'b0;

        add_vec(2'b00, 32'h0000_00ff, 24'h0000ff, 1'b0, 1'b0, dp_lat(0));
        add_vec(2'b00, 32'hff00_0000, 24'h0004ff, 1'b0, 1'b0, dp_lat(4));
        add_vec(2'b00, 32'h0000_0000, 24'h000000, 1'b0, 1'b0, dp_lat(0));
        add_vec(2'b00, 32'h8000_0001, 24'h000106, 1'b0, 1'b0, dp_lat(1));
        add_vec(2'b00, 32'h0000_03fc, 24'h000fff, 1'b0, 1'b0, dp_lat(15));
        add_vec(2'b00, 32'h0000_0101, 24'h000000, 1'b1, 1'b0, ALT_ON ? 2 * FULL_FAIL : FULL_FAIL);
        if (ALT_ON)
            add_vec(2'b00, 32'hffff_ff00, 24'h0000ff, 1'b0, 1'b1, FULL_FAIL + dp_lat(0));
        else
            add_vec(2'b00, 32'hffff_ff00, 24'h000000, 1'b1, 1'b0, FULL_FAIL);
        add_vec(2'b01, 32'h0000_0fff, 24'h000fff, 1'b0, 1'b0, 0);
        add_vec(2'b01, 32'h0000_1000, 24'h000000, 1'b1, 1'b0, 0);
        add_vec(2'b10, 32'hffff_fffc, 24'hffffff, 1'b0, 1'b0, 0);
        add_vec(2'b10, 32'h01ff_fffc, 24'h7fffff, 1'b0, 1'b0, 0);
        add_vec(2'b10, 32'hfe00_0000, 24'h800000, 1'b0, 1'b0, 0);
        add_vec(2'b10, 32'h0000_0002, 24'h000000, 1'b1, 1'b0, 0);
        add_vec(2'b10, 32'h0200_0000, 24'h000000, 1'b1, 1'b0, 0);
        add_vec(2'b11, 32'h0000_0000, 24'h000000, 1'b1, 1'b0, 0);

        for (int i = 0; i < num_vecs; i++) begin
            issue(vecs[i].src, vecs[i].val, lat);
            $display("vec %0d src=%0d value=0x%08h -> imm=0x%06h err=%0d alt=%0d lat=%0d",
                     i, vecs[i].src, vecs[i].val, instr_imm, err, alt, lat);
            check("latency",   lat,                       vecs[i].exp_lat);
            check("instr_imm", {8'd0, instr_imm},         {8'd0, vecs[i].exp_imm});
            check("err",       {31'd0, err},              {31'd0, vecs[i].exp_err});
            check("alt",       {31'd0, alt},              {31'd0, vecs[i].exp_alt});
            check("in_ready_in_done", {31'd0, in_ready},  32'd0);
            release_result();
            check("idle_after_ack",  {31'd0, out_valid},  32'd0);
            check("imm_cleared",     {8'd0, instr_imm},   32'd0);
            check("err_cleared",     {31'd0, err},        32'd0);
        end

        // Reset in the middle of a failing search discards it.
        in_valid = 1'b1; imm_src = 2'b00; value = 32'h0000_0101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_search_busy", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset mid-search: in_ready=%0d out_valid=%0d imm=0x%06h err=%0d",
                 in_ready, out_valid, instr_imm, err);
        check("rst_search_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_search_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_search_imm",       {8'd0, instr_imm},  32'd0);
        check("rst_search_err",       {31'd0, err},       32'd0);
        stayed_low = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) stayed_low = 1'b0;
        end
        check("rst_search_no_result", {31'd0, stayed_low}, 32'd1);

        // Backpressure in DONE holds the result.
        issue(2'b10, 32'hffff_fffc, lat);
        check("bp_latency", lat, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            $display("backpressure cycle %0d: out_valid=%0d imm=0x%06h err=%0d in_ready=%0d",
                     k, out_valid, instr_imm, err, in_ready);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_imm",       {8'd0, instr_imm},  32'h00ff_ffff);
            check("bp_err",       {31'd0, err},       32'd0);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
        end
        release_result();
        check("bp_release_idle", {31'd0, in_ready}, 32'd1);
        issue(2'b00, 32'h0000_00ff, lat);
        $display("post-backpressure request: imm=0x%06h err=%0d lat=%0d", instr_imm, err, lat);
        check("bp_next_lat", lat, dp_lat(0));
        check("bp_next_imm", {8'd0, instr_imm}, 32'h0000_00ff);
        release_result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
